// File: rtl/instruction_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package instruction_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_WRITE,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned ADDR_STRIDE    = 4;
  localparam int unsigned IMEM_WORDS     = 64;
  localparam int unsigned BYTE_IDX_W     = 2;

endpackage

// File: rtl/instruction_loader_byte_packer.sv
// Big-endian byte-to-word shift register: the first byte of a word ends up in [31:24].
module instruction_loader_byte_packer
  import instruction_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clear,
  input  logic        i_shift_en,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_full_c
);

  logic [31:0]           r_word;
  logic [BYTE_IDX_W-1:0] r_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word <= '0;
      r_idx  <= '0;
    end else if (i_clear) begin
      r_word <= '0;
      r_idx  <= '0;
    end else if (i_shift_en) begin
      r_word <= {r_word[23:0], i_byte};
      r_idx  <= r_idx + BYTE_IDX_W'(1);
    end
  end

  assign o_word = r_word;
  // High while the byte being shifted in completes the word.
  assign o_word_full_c = i_shift_en && (r_idx == BYTE_IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/instruction_loader.sv
// Loads a byte stream into instruction memory as big-endian words while holding the CPU.
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int unsigned       ADDR_W        = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR     = '0,
  parameter int unsigned       MEM_WORDS     = IMEM_WORDS,
  parameter int unsigned       CNT_W         = 7,
  parameter int unsigned       TIMEOUT_CYC   = 1024,
  parameter bit                HOLD_AT_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load_start,
  input  logic [CNT_W-1:0]  i_word_count,
  input  logic [7:0]        i_in_data,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [31:0]       o_wr_data,
  output logic              o_cpu_hold,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [31:0]       o_checksum,
  output logic [CNT_W-1:0]  o_words_written
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

  state_t             r_state;
  logic               r_in_ready;
  logic               r_wr_en;
  logic [ADDR_W-1:0]  r_ptr;
  logic               r_hold;
  logic               r_busy;
  logic               r_done;
  logic               r_err;
  logic [31:0]        r_csum;
  logic [CNT_W-1:0]   r_wcnt;
  logic [CNT_W-1:0]   r_target;
  logic [TMO_W-1:0]   r_tmo;

  logic               w_xfer;
  logic               w_start_ok;
  logic               w_clear;
  logic               w_word_full;
  logic [31:0]        w_word;

  assign w_xfer     = i_in_valid && r_in_ready;
  assign w_start_ok = i_load_start && ((r_state == ST_IDLE) || (r_state == ST_ERR));
  // Drop any partial word when a load begins and re-arm the packer after each write.
  assign w_clear    = w_start_ok || (r_state == ST_WRITE);

  instruction_loader_byte_packer u_packer (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_clear       (w_clear),
    .i_shift_en    (w_xfer),
    .i_byte        (i_in_data),
    .o_word        (w_word),
    .o_word_full_c (w_word_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_in_ready <= 1'b0;
      r_wr_en    <= 1'b0;
      r_ptr      <= BASE_ADDR;
      r_hold     <= HOLD_AT_RESET;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_csum     <= '0;
      r_wcnt     <= '0;
      r_target   <= '0;
      r_tmo      <= '0;
    end else begin
      r_done  <= 1'b0;
      r_wr_en <= 1'b0;
      case (r_state)
        ST_IDLE, ST_ERR: begin
          if (i_load_start) begin
            r_csum   <= '0;
            r_wcnt   <= '0;
            r_err    <= 1'b0;
            r_tmo    <= '0;
            r_ptr    <= BASE_ADDR;
            r_target <= i_word_count;
            if (i_word_count == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_hold  <= 1'b0;
            end else if (i_word_count > CNT_W'(MEM_WORDS)) begin
              r_state <= ST_ERR;
              r_err   <= 1'b1;
              r_hold  <= 1'b1;
            end else begin
              r_state    <= ST_RECV;
              r_in_ready <= 1'b1;
              r_busy     <= 1'b1;
              r_hold     <= 1'b1;
            end
          end
        end
        ST_RECV: begin
          if (w_xfer) begin
            r_tmo <= '0;
            if (w_word_full) begin
              r_state    <= ST_WRITE;
              r_in_ready <= 1'b0;
              r_wr_en    <= 1'b1;
            end
          end else if (r_tmo == TMO_W'(TIMEOUT_CYC - 1)) begin
            r_state    <= ST_ERR;
            r_err      <= 1'b1;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end
        ST_WRITE: begin
          r_csum <= r_csum ^ w_word;
          r_wcnt <= r_wcnt + CNT_W'(1);
          r_ptr  <= r_ptr + ADDR_W'(ADDR_STRIDE);
          if ((r_wcnt + CNT_W'(1)) == r_target) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_hold  <= 1'b0;
            r_busy  <= 1'b0;
          end else begin
            r_state    <= ST_RECV;
            r_in_ready <= 1'b1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // The packer register holds the complete word throughout the write cycle.
  assign o_in_ready      = r_in_ready;
  assign o_wr_en         = r_wr_en;
  assign o_wr_addr       = r_ptr;
  assign o_wr_data       = w_word;
  assign o_cpu_hold      = r_hold;
  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_err           = r_err;
  assign o_checksum      = r_csum;
  assign o_words_written = r_wcnt;

endmodule

// File: tb/tb_instruction_loader.sv
// Randomized bench for instruction_loader checked against a transaction-level model.
module tb_instruction_loader;

  localparam int unsigned TMO  = 1024;
  localparam int unsigned MEMW = 64;
  localparam logic [31:0] BASE = 32'h0;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_start = 1'b0;
  logic [6:0]  word_count = '0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready, wr_en, cpu_hold, busy, done, err;
  logic [31:0] wr_addr, wr_data, checksum;
  logic [6:0]  words_written;

  int total = 0;
  int bad = 0;
  int dcount = 0;
  logic [31:0] wlog_a[$];
  logic [31:0] wlog_d[$];

  instruction_loader dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_load_start    (load_start),
    .i_word_count    (word_count),
    .i_in_data       (in_data),
    .i_in_valid      (in_valid),
    .o_in_ready      (in_ready),
    .o_wr_en         (wr_en),
    .o_wr_addr       (wr_addr),
    .o_wr_data       (wr_data),
    .o_cpu_hold      (cpu_hold),
    .o_busy          (busy),
    .o_done          (done),
    .o_err           (err),
    .o_checksum      (checksum),
    .o_words_written (words_written)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs for the current cycle, advanced once per clock from the protocol rules.
  logic        e_rdy = 1'b0, e_wen = 1'b0, e_done = 1'b0, e_err = 1'b0;
  logic        e_hold = 1'b1, e_busy = 1'b0;
  logic [31:0] e_waddr = BASE, e_wdata = '0, e_csum = '0;
  int          e_wcnt = 0, m_target = 0, m_idle = 0;
  logic        m_was_wen, m_was_done;
  bq_t         m_q;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_rdy = 1'b0; e_wen = 1'b0; e_done = 1'b0; e_err = 1'b0;
      e_hold = 1'b1; e_busy = 1'b0; e_waddr = BASE; e_wdata = '0;
      e_csum = '0; e_wcnt = 0; m_idle = 0; m_q.delete();
    end else begin
      m_was_wen  = e_wen;
      m_was_done = e_done;
      e_wen  = 1'b0;
      e_done = 1'b0;
      if (m_was_wen) begin
        e_csum = e_csum ^ e_wdata;
        e_wcnt++;
        if (e_wcnt == m_target) begin
          e_done = 1'b1; e_hold = 1'b0; e_busy = 1'b0; e_rdy = 1'b0;
        end else begin
          e_rdy = 1'b1;
        end
      end else if (e_rdy) begin
        if (in_valid) begin
          m_q.push_back(in_data);
          m_idle = 0;
          if (m_q.size() == 4) begin
            e_wdata = {m_q[0], m_q[1], m_q[2], m_q[3]};
            e_waddr = BASE + 32'(4 * e_wcnt);
            m_q.delete();
            e_wen = 1'b1;
            e_rdy = 1'b0;
          end
        end else begin
          m_idle++;
          if (m_idle == TMO) begin
            e_err = 1'b1; e_rdy = 1'b0; e_busy = 1'b0;
          end
        end
      end else if (!m_was_done && !e_busy && load_start) begin
        e_csum = '0; e_wcnt = 0; e_err = 1'b0; m_idle = 0; m_q.delete();
        m_target = int'(word_count);
        if (m_target == 0) begin
          e_done = 1'b1; e_hold = 1'b0;
        end else if (m_target > MEMW) begin
          e_err = 1'b1; e_hold = 1'b1;
        end else begin
          e_rdy = 1'b1; e_busy = 1'b1; e_hold = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready", 32'(in_ready), 32'(e_rdy));
    chk("wr_en", 32'(wr_en), 32'(e_wen));
    chk("cpu_hold", 32'(cpu_hold), 32'(e_hold));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("done", 32'(done), 32'(e_done));
    chk("err", 32'(err), 32'(e_err));
    chk("checksum", checksum, e_csum);
    chk("words_written", 32'(words_written), 32'(e_wcnt));
    if (e_wen) begin
      chk("wr_addr", wr_addr, e_waddr);
      chk("wr_data", wr_data, e_wdata);
    end
    if (wr_en) begin
      wlog_a.push_back(wr_addr);
      wlog_d.push_back(wr_data);
    end
    if (done) dcount++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input int wc);
    load_start = 1'b1;
    word_count = 7'(wc);
    tick();
    load_start = 1'b0;
  endtask

  // mode 0: back-to-back, 1: valid every other cycle, 2: random valid plus stray load_start pulses
  task automatic send_bytes(input bq_t bs, input int mode);
    int i;
    int cyc;
    logic hs;
    i = 0;
    cyc = 0;
    while (i < bs.size() && cyc < 5000) begin
      in_data = bs[i];
      case (mode)
        0: in_valid = 1'b1;
        1: in_valid = (cyc % 2) == 0;
        default: in_valid = $urandom_range(0, 2) != 0;
      endcase
      if (mode == 2) begin
        load_start = $urandom_range(0, 15) == 0;
        word_count = 7'($urandom_range(0, 127));
      end
      @(negedge clk);
      hs = in_valid && in_ready;
      tick();
      if (hs) i++;
      cyc++;
    end
    in_valid = 1'b0;
    load_start = 1'b0;
    if (i < bs.size()) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got %0d bytes expected %0d", i, bs.size());
    end
  endtask

  initial begin
    bq_t bs;
    int n;
    int wc;
    int sel;
    logic got_err;

    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("rst_cpu_hold", 32'(cpu_hold), 32'h1);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_wr_en", 32'(wr_en), 32'h0);
    chk("rst_checksum", checksum, 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_wr_addr", wr_addr, 32'h0);
    chk("rst_wr_data", wr_data, 32'h0);

    // Two words streamed back-to-back
    wlog_a.delete(); wlog_d.delete(); dcount = 0;
    start_load(2);
    bs = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h07};
    send_bytes(bs, 0);
    repeat (4) tick();
    chk("two_wr_count", 32'(wlog_a.size()), 32'd2);
    if (wlog_a.size() == 2) begin
      chk("two_addr0", wlog_a[0], 32'h0);
      chk("two_data0", wlog_d[0], 32'h20080005);
      chk("two_addr1", wlog_a[1], 32'h4);
      chk("two_data1", wlog_d[1], 32'h20090007);
    end
    chk("two_checksum", checksum, 32'h00010002);
    chk("two_model_csum", e_csum, 32'h00010002);
    chk("two_words", 32'(words_written), 32'd2);
    chk("two_done_pulses", 32'(dcount), 32'd1);
    chk("two_cpu_hold", 32'(cpu_hold), 32'h0);

    // One word with a gappy source
    wlog_a.delete(); wlog_d.delete();
    start_load(1);
    bs = '{8'h8C, 8'h01, 8'h00, 8'h00};
    send_bytes(bs, 1);
    repeat (4) tick();
    chk("gap_wr_count", 32'(wlog_d.size()), 32'd1);
    if (wlog_d.size() == 1) chk("gap_data", wlog_d[0], 32'h8C010000);
    chk("gap_checksum", checksum, 32'h8C010000);

    // Stream stalls mid-load: expect a timeout abort
    wlog_a.delete(); wlog_d.delete(); dcount = 0;
    start_load(3);
    bs = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_bytes(bs, 0);
    n = 0;
    got_err = 1'b0;
    while (!got_err && n < int'(TMO) + 50) begin
      @(negedge clk);
      if (err) got_err = 1'b1;
      else begin
        @(posedge clk);
        n++;
      end
    end
    tick();
    chk("tmo_cycles", 32'(n), 32'(TMO));
    chk("tmo_wr_count", 32'(wlog_d.size()), 32'd1);
    chk("tmo_cpu_hold", 32'(cpu_hold), 32'h1);
    chk("tmo_done_pulses", 32'(dcount), 32'd0);
    chk("tmo_words", 32'(words_written), 32'd1);

    // Oversize request, then an empty load clears the error
    wlog_a.delete(); wlog_d.delete();
    start_load(MEMW + 1);
    repeat (2) tick();
    chk("big_err", 32'(err), 32'h1);
    chk("big_in_ready", 32'(in_ready), 32'h0);
    chk("big_wr_count", 32'(wlog_d.size()), 32'd0);
    start_load(0);
    chk("zero_done", 32'(done), 32'h1);
    chk("zero_err", 32'(err), 32'h0);
    chk("zero_cpu_hold", 32'(cpu_hold), 32'h0);
    tick();
    chk("zero_done_low", 32'(done), 32'h0);

    // Reset in the middle of word 1
    wlog_a.delete(); wlog_d.delete();
    start_load(2);
    bs = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2};
    send_bytes(bs, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_cpu_hold", 32'(cpu_hold), 32'h1);
    chk("mid_rst_words", 32'(words_written), 32'h0);
    chk("mid_rst_checksum", checksum, 32'h0);
    chk("mid_rst_wr_addr", wr_addr, 32'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("mid_rst_wr_count", 32'(wlog_d.size()), 32'd1);
    start_load(1);
    bs = '{8'hC0, 8'hFF, 8'hEE, 8'h01};
    send_bytes(bs, 0);
    repeat (4) tick();
    chk("post_rst_wr_count", 32'(wlog_d.size()), 32'd2);
    if (wlog_d.size() == 2) begin
      chk("post_rst_addr", wlog_a[1], BASE);
      chk("post_rst_data", wlog_d[1], 32'hC0FFEE01);
    end

    // Random loads with random gaps and stray load_start pulses
    for (int it = 0; it < 30; it++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0) wc = 0;
      else if (sel == 1) wc = $urandom_range(MEMW + 1, 127);
      else wc = $urandom_range(1, 6);
      start_load(wc);
      if (wc >= 1 && wc <= MEMW) begin
        bs.delete();
        for (int b = 0; b < 4 * wc; b++) bs.push_back(8'($urandom_range(0, 255)));
        send_bytes(bs, 2);
      end
      repeat (3) tick();
    end

    repeat (5) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
